// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receive framer.
package uart_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StCmd,
    StLen,
    StPay,
    StChk,
    StHold
  } state_e;

  localparam logic [7:0] SyncDefault = 8'hA5;
  localparam int unsigned ByteW = 8;

  // Increment that sticks at the all-ones value of a counter of the given width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Byte-stream input and parallel frame output of the framer, bundled as one interface.
interface uart_rx_framer_if
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  logic [8:0]               din;
  logic                     din_valid;
  logic                     din_ready;
  logic                     frame_valid;
  logic                     frame_ready;
  logic [ByteW-1:0]         frame_cmd;
  logic [LenW-1:0]          frame_len;
  logic [ByteW*MAX_LEN-1:0] frame_data;

  modport master (
    output din, din_valid, frame_ready,
    input  din_ready, frame_valid, frame_cmd, frame_len, frame_data
  );

  modport slave (
    input  din, din_valid, frame_ready,
    output din_ready, frame_valid, frame_cmd, frame_len, frame_data
  );

endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: expire is raised while enabled and the count sits at TIMEOUT-1.
module uart_frame_timer #(
  parameter int unsigned TIMEOUT = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire = enable && (32'(cnt_q) == TIMEOUT - 1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// Hunts for SYNC, assembles SYNC/CMD/LEN/payload/CHK frames and hands good ones out whole.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 16,
  parameter logic [7:0]  SYNC      = SyncDefault,
  parameter int unsigned TIMEOUT   = 500000,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_rx_framer_if.slave      bus,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] len_err_cnt,
  output logic [CNT_WIDTH-1:0] chk_err_cnt,
  output logic [CNT_WIDTH-1:0] to_err_cnt
);
  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  state_e                   state_q, state_d;
  logic [ByteW-1:0]         cmd_q, cmd_d;
  logic [LenW-1:0]          len_q, len_d;
  logic [LenW-1:0]          idx_q, idx_d;
  logic [ByteW-1:0]         sum_q, sum_d;
  logic [ByteW*MAX_LEN-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]     par_q, par_d, len_err_q, len_err_d;
  logic [CNT_WIDTH-1:0]     chk_q, chk_d, to_q, to_d;

  logic             accept, in_frame, expire, timeout, par_flag;
  logic [ByteW-1:0] rx_byte, sum_next;

  assign rx_byte  = bus.din[ByteW-1:0];
  assign par_flag = bus.din[8];
  assign accept   = bus.din_valid && bus.din_ready;
  assign in_frame = (state_q == StCmd) || (state_q == StLen) ||
                    (state_q == StPay) || (state_q == StChk);
  // An accepted byte on the expiring cycle beats the timeout.
  assign timeout  = in_frame && expire && !accept;
  assign sum_next = sum_q + rx_byte;

  uart_frame_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept || !in_frame),
    .enable (in_frame),
    .expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    data_d    = data_q;
    par_d     = par_q;
    len_err_d = len_err_q;
    chk_d     = chk_q;
    to_d      = to_q;

    unique case (state_q)
      StHunt: begin
        if (accept && !par_flag && rx_byte == SYNC) begin
          state_d = StCmd;
          data_d  = '0;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      StCmd, StLen, StPay, StChk: begin
        if (accept && par_flag) begin
          state_d = StHunt;
          par_d   = CNT_WIDTH'(sat_inc(32'(par_q), CNT_WIDTH));
        end else if (accept) begin
          unique case (state_q)
            StCmd: begin
              cmd_d   = rx_byte;
              sum_d   = sum_next;
              state_d = StLen;
            end
            StLen: begin
              if (32'(rx_byte) > MAX_LEN) begin
                state_d   = StHunt;
                len_err_d = CNT_WIDTH'(sat_inc(32'(len_err_q), CNT_WIDTH));
              end else begin
                len_d   = LenW'(rx_byte);
                sum_d   = sum_next;
                state_d = (rx_byte == '0) ? StChk : StPay;
              end
            end
            StPay: begin
              for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (idx_q == LenW'(i)) data_d[ByteW*i +: ByteW] = rx_byte;
              end
              sum_d = sum_next;
              idx_d = idx_q + LenW'(1);
              if (idx_q + LenW'(1) == len_q) state_d = StChk;
            end
            default: begin
              if (sum_next == '0) begin
                state_d = StHold;
              end else begin
                state_d = StHunt;
                chk_d   = CNT_WIDTH'(sat_inc(32'(chk_q), CNT_WIDTH));
              end
            end
          endcase
        end else if (timeout) begin
          state_d = StHunt;
          to_d    = CNT_WIDTH'(sat_inc(32'(to_q), CNT_WIDTH));
        end
      end
      StHold: begin
        if (bus.frame_ready) state_d = StHunt;
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StHunt;
      cmd_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      data_q    <= '0;
      par_q     <= '0;
      len_err_q <= '0;
      chk_q     <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      data_q    <= data_d;
      par_q     <= par_d;
      len_err_q <= len_err_d;
      chk_q     <= chk_d;
      to_q      <= to_d;
    end
  end

  assign bus.din_ready   = (state_q != StHold);
  assign bus.frame_valid = (state_q == StHold);
  assign bus.frame_cmd   = cmd_q;
  assign bus.frame_len   = len_q;
  assign bus.frame_data  = data_q;
  assign par_err_cnt     = par_q;
  assign len_err_cnt     = len_err_q;
  assign chk_err_cnt     = chk_q;
  assign to_err_cnt      = to_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: directed cases plus randomized frames and faults.
module tb_uart_rx_framer;
  localparam int unsigned MaxLen  = 16;
  localparam int unsigned Timeout = 20;
  localparam int unsigned CntW    = 8;

  typedef struct {
    logic [7:0]   cmd;
    int           len;
    logic [127:0] data;
  } frame_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_rx_framer_if #(.MAX_LEN(MaxLen)) bus ();
  logic [CntW-1:0] par_err_cnt, len_err_cnt, chk_err_cnt, to_err_cnt;

  uart_rx_framer #(
    .MAX_LEN  (MaxLen),
    .SYNC     (8'hA5),
    .TIMEOUT  (Timeout),
    .CNT_WIDTH(CntW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .par_err_cnt(par_err_cnt),
    .len_err_cnt(len_err_cnt),
    .chk_err_cnt(chk_err_cnt),
    .to_err_cnt (to_err_cnt)
  );

  int errors = 0;
  int checks = 0;
  int exp_par = 0, exp_len = 0, exp_chk = 0, exp_to = 0;
  bit rdy_random = 1'b0;
  frame_t exp_q[$];
  logic [8:0] fb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_par_err_cnt"}, par_err_cnt, exp_par);
    check({tag, "_len_err_cnt"}, len_err_cnt, exp_len);
    check({tag, "_chk_err_cnt"}, chk_err_cnt, exp_chk);
    check({tag, "_to_err_cnt"}, to_err_cnt, exp_to);
  endtask

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // One byte; returns #1 after the accepting edge.
  task automatic send(input logic [8:0] b, input int gap);
    int guard;
    repeat (gap) @(posedge clock);
    @(negedge clock);
    bus.din       = b;
    bus.din_valid = 1'b1;
    guard         = 0;
    while (!bus.din_ready && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    check("din_ready_wait", bus.din_ready, 1'b1);
    @(posedge clock);
    #1 bus.din_valid = 1'b0;
  endtask

  task automatic send_fb(input bit random_gaps);
    for (int i = 0; i < fb.size(); i++) begin
      int g;
      g = 0;
      if (random_gaps) g = ($urandom_range(0, 9) == 0) ? 19 : $urandom_range(0, 2);
      send(fb[i], g);
    end
  endtask

  // Frame built from the protocol rules: checksum makes the byte sum vanish mod 256.
  task automatic make_frame(input logic [7:0] cmd, input int len, input bit corrupt,
                            output frame_t f);
    int s, chk;
    f.cmd  = cmd;
    f.len  = len;
    f.data = '0;
    fb.delete();
    fb.push_back({1'b0, 8'hA5});
    fb.push_back({1'b0, cmd});
    fb.push_back({1'b0, 8'(len)});
    s = int'(cmd) + len;
    for (int i = 0; i < len; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 255));
      f.data[8*i +: 8] = p;
      fb.push_back({1'b0, p});
      s += int'(p);
    end
    chk = (256 - (s % 256)) % 256;
    if (corrupt) chk = (chk + 1 + $urandom_range(0, 254)) % 256;
    fb.push_back({1'b0, 8'(chk)});
  endtask

  // Monitor: compares every presented frame to the scoreboard head, pops on handshake.
  initial begin
    forever begin
      @(negedge clock);
      #1 if (rdy_random) bus.frame_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (!reset && bus.frame_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got cmd %0h len %0d expected no frame",
                   bus.frame_cmd, bus.frame_len);
        end else begin
          check("frame_cmd", bus.frame_cmd, exp_q[0].cmd);
          check("frame_len", bus.frame_len, exp_q[0].len);
          check("frame_data", bus.frame_data, exp_q[0].data);
          if (bus.frame_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    frame_t f;
    int guard;
    bus.din         = '0;
    bus.din_valid   = 1'b0;
    bus.frame_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_din_ready", bus.din_ready, 1'b1);
    check("rst_frame_valid", bus.frame_valid, 1'b0);
    check("rst_frame_cmd", bus.frame_cmd, 8'h00);
    check("rst_frame_len", bus.frame_len, 0);
    check("rst_frame_data", bus.frame_data, 0);
    check_counters("rst");

    // Good frame held by the sink for five cycles.
    f.cmd = 8'h10; f.len = 2; f.data = '0; f.data[15:0] = 16'h2211;
    exp_q.push_back(f);
    fb = '{9'h0A5, 9'h010, 9'h002, 9'h011, 9'h022, 9'h0BB};
    send_fb(1'b0);
    check("valid_after_chk", bus.frame_valid, 1'b1);
    repeat (5) begin
      @(negedge clock);
      check("hold_din_ready", bus.din_ready, 1'b0);
      check("hold_frame_valid", bus.frame_valid, 1'b1);
    end
    bus.frame_ready = 1'b1;
    @(negedge clock);
    bus.frame_ready = 1'b0;
    check("after_hs_din_ready", bus.din_ready, 1'b1);
    check("after_hs_frame_valid", bus.frame_valid, 1'b0);
    rdy_random = 1'b1;

    // Bad checksum then a good frame.
    fb = '{9'h0A5, 9'h010, 9'h002, 9'h011, 9'h022, 9'h0BC};
    send_fb(1'b0);
    exp_chk = sat(exp_chk);
    @(negedge clock);
    check_counters("badchk");
    exp_q.push_back(f);
    fb = '{9'h0A5, 9'h010, 9'h002, 9'h011, 9'h022, 9'h0BB};
    send_fb(1'b0);

    // Leading garbage, zero-length frame.
    f.cmd = 8'h01; f.len = 0; f.data = '0;
    exp_q.push_back(f);
    fb = '{9'h000, 9'h0FF, 9'h011, 9'h0A5, 9'h001, 9'h000, 9'h0FF};
    send_fb(1'b0);
    @(negedge clock);
    check_counters("resync");

    // Parity abort and oversize length.
    fb = '{9'h0A5, 9'h010, 9'h102};
    send_fb(1'b0);
    exp_par = sat(exp_par);
    @(negedge clock);
    check("par_din_ready", bus.din_ready, 1'b1);
    check_counters("parity");
    fb = '{9'h0A5, 9'h010, 9'h011};
    send_fb(1'b0);
    exp_len = sat(exp_len);
    @(negedge clock);
    check_counters("badlen");

    // Timeout, then a byte landing exactly on the expiring cycle.
    fb = '{9'h0A5, 9'h010};
    send_fb(1'b0);
    repeat (Timeout) @(posedge clock);
    exp_to = sat(exp_to);
    @(negedge clock);
    check_counters("timeout");
    f.cmd = 8'h10; f.len = 0; f.data = '0;
    exp_q.push_back(f);
    send(9'h0A5, 0);
    send(9'h010, 0);
    send(9'h000, Timeout - 1);
    send(9'h0F0, 0);
    @(negedge clock);
    check_counters("edge_timeout");

    // Reset in the middle of the payload.
    fb = '{9'h0A5, 9'h010, 9'h004, 9'h011, 9'h022};
    send_fb(1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_par = 0; exp_len = 0; exp_chk = 0; exp_to = 0;
    check("midpay_din_ready", bus.din_ready, 1'b1);
    check("midpay_frame_valid", bus.frame_valid, 1'b0);
    check("midpay_frame_cmd", bus.frame_cmd, 8'h00);
    check("midpay_frame_len", bus.frame_len, 0);
    check("midpay_frame_data", bus.frame_data, 0);
    check_counters("midpay");

    // Randomized scenarios.
    for (int n = 0; n < 150; n++) begin
      int kind, p, ng;
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        send({(v == 8'hA5) ? 1'b1 : 1'($urandom_range(0, 1)), v}, $urandom_range(0, 3));
      end
      kind = $urandom_range(0, 5);
      make_frame(8'($urandom_range(0, 255)), $urandom_range(0, MaxLen), kind == 2, f);
      unique case (kind)
        0, 1: begin
          exp_q.push_back(f);
          send_fb(1'b1);
        end
        2: begin
          send_fb(1'b1);
          exp_chk = sat(exp_chk);
        end
        3: begin
          p = $urandom_range(1, fb.size() - 1);
          fb = fb[0:p-1];
          fb.push_back({1'b1, 8'($urandom_range(0, 255))});
          send_fb(1'b1);
          exp_par = sat(exp_par);
        end
        4: begin
          fb = fb[0:1];
          fb.push_back({1'b0, 8'($urandom_range(MaxLen + 1, 255))});
          send_fb(1'b1);
          exp_len = sat(exp_len);
        end
        default: begin
          p = $urandom_range(1, fb.size() - 1);
          fb = fb[0:p-1];
          send_fb(1'b1);
          repeat (Timeout + $urandom_range(0, 5)) @(posedge clock);
          exp_to = sat(exp_to);
        end
      endcase
      @(negedge clock);
      check_counters("rand");
    end

    // Saturation of the checksum error counter.
    for (int n = 0; n < 300; n++) begin
      make_frame(8'($urandom_range(0, 255)), 0, 1'b1, f);
      send_fb(1'b0);
      exp_chk = sat(exp_chk);
    end
    @(negedge clock);
    check("chk_saturated", chk_err_cnt, 8'd255);
    check_counters("sat");

    guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
